// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and
// its consumers (renderer, output pins).
//   ce           pixel enable into the generator
//   hsync/vsync  sync outputs, polarity set by the generator parameters
//   video_active current pixel is inside the visible area
//   pix_x/pix_y  visible column/row, 0 during blanking
//   frame_start  one-clk pulse at pixel (0,0)
//   line_end     one-clk pulse at the last count of each line
//   frame_count  completed-frame counter, wraps
interface vga_timing_gen_if;
    logic        ce;
    logic        hsync;
    logic        vsync;
    logic        video_active;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic        line_end;
    logic [15:0] frame_count;

    modport master (
        input  ce,
        output hsync, vsync, video_active, pix_x, pix_y,
               frame_start, line_end, frame_count
    );

    modport slave (
        output ce,
        input  hsync, vsync, video_active, pix_x, pix_y,
               frame_start, line_end, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator (default 1024x768 XGA).
// Ports:
//   clk  pixel-domain clock
//   rst  asynchronous reset, active-high
//   bus  vga_timing_gen_if master: ce in; sync, active, pixel coordinates,
//        frame_start/line_end pulses and frame_count out
// All outputs are registered decodes of the current (h_cnt, v_cnt), so they
// trail the counters by one ce-cycle and are mutually aligned.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 136,
    parameter int unsigned H_BP       = 160,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned V_FP       = 3,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BP       = 29,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [15:0] frame_cnt;

    logic h_last, v_last, h_vis, v_vis, h_sync_on, v_sync_on;

    always_comb begin
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        h_vis     = (h_cnt < H_VIS);
        v_vis     = (v_cnt < V_VIS);
        h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    assign bus.frame_count = frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt            <= '0;
            v_cnt            <= '0;
            frame_cnt        <= '0;
            bus.hsync        <= ~H_SYNC_POL;
            bus.vsync        <= ~V_SYNC_POL;
            bus.video_active <= 1'b0;
            bus.pix_x        <= '0;
            bus.pix_y        <= '0;
            bus.frame_start  <= 1'b0;
            bus.line_end     <= 1'b0;
        end else if (bus.ce) begin
            bus.hsync        <= h_sync_on ? H_SYNC_POL : ~H_SYNC_POL;
            bus.vsync        <= v_sync_on ? V_SYNC_POL : ~V_SYNC_POL;
            bus.video_active <= h_vis && v_vis;
            bus.pix_x        <= h_vis ? h_cnt[9:0] : '0;
            bus.pix_y        <= v_vis ? v_cnt : '0;
            bus.frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            bus.line_end     <= h_last;

            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end else begin
            // Pulses must not stretch across idle (ce = 0) clocks.
            bus.frame_start <= 1'b0;
            bus.line_end    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen using a reduced
// raster so several whole frames fit in a short run. Expected outputs are
// derived from the absolute ce-cycle index since reset.
module tb_vga_timing_gen;

    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 2;
    localparam int unsigned HS  = 4;
    localparam int unsigned HBP = 3;
    localparam int unsigned VA  = 10;
    localparam int unsigned VFP = 2;
    localparam int unsigned VS  = 3;
    localparam int unsigned VBP = 2;
    localparam logic        HP  = 1'b0;
    localparam logic        VP  = 1'b0;
    localparam int unsigned HT  = HA + HFP + HS + HBP;
    localparam int unsigned VT  = VA + VFP + VS + VBP;
    localparam int unsigned FT  = HT * VT;

    // {hsync, vsync, active, pix_x[10], pix_y[10], frame_start, line_end, frame_count[16]}
    localparam logic [40:0] RST_VAL = {~HP, ~VP, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0};

    typedef struct {
        int unsigned k;
        logic [40:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_gen_if bus ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb_q[$];
    logic [40:0] last = RST_VAL;
    int unsigned k = 0;
    int unsigned fc_base = 0;
    int unsigned k_force = 0;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] dut_out();
        return {bus.hsync, bus.vsync, bus.video_active, bus.pix_x, bus.pix_y,
                bus.frame_start, bus.line_end, bus.frame_count};
    endfunction

    // Expected outputs for the k-th ce-cycle since reset (raster position k).
    function automatic logic [40:0] exp_at(input int unsigned idx);
        int unsigned h = idx % HT;
        int unsigned v = (idx / HT) % VT;
        logic        act = (h < HA) && (v < VA);
        logic        hs  = (h >= HA + HFP && h < HA + HFP + HS) ? HP : ~HP;
        logic        vs  = (v >= VA + VFP && v < VA + VFP + VS) ? VP : ~VP;
        logic [9:0]  px  = (h < HA) ? 10'(h) : 10'd0;
        logic [9:0]  py  = (v < VA) ? 10'(v) : 10'd0;
        logic        fs  = (h == 0) && (v == 0);
        logic        le  = (h == HT - 1);
        // Frames completed at the end of this ce-cycle, counted from the preload.
        logic [15:0] fc  = 16'(fc_base + (idx + 1) / FT - k_force / FT);
        return {hs, vs, act, px, py, fs, le, fc};
    endfunction

    function automatic logic [40:0] held(input logic [40:0] v);
        logic [40:0] r = v;
        r[17] = 1'b0;
        r[16] = 1'b0;
        return r;
    endfunction

    task automatic step(input logic c);
        exp_t e;
        bus.ce = c;
        if (c) begin
            e.k = k;
            e.v = exp_at(k);
            sb_q.push_back(e);
            k++;
        end
        @(negedge clk);
    endtask

    // Monitor: one output per ce edge, otherwise outputs must hold with pulses low.
    initial begin
        logic c, r;
        exp_t e;
        forever begin
            @(posedge clk);
            c = bus.ce;
            r = rst;
            #1;
            if (c && !r) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", dut_out(), 41'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("out_k%0d", e.k), dut_out(), e.v);
                    last = held(e.v);
                end
            end else begin
                check("hold", dut_out(), held(last));
            end
        end
    end

    initial begin
        bus.ce = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), RST_VAL);
        rst = 1'b0;

        // Continuous run: two full frames plus a little.
        for (int i = 0; i < int'(2 * FT + 10); i++) step(1'b1);

        // Random ce.
        for (int i = 0; i < int'(FT + FT / 2); i++) step(1'($urandom_range(0, 1)));

        // Strict 1/0 toggle for over a frame.
        for (int i = 0; i < int'(2 * FT + 20); i++) step((i % 2) == 0);

        // Walk to a mid-frame position, then reset asynchronously mid-cycle.
        for (int i = 0; i < int'(FT) && (k % FT) != 7 * HT + 9; i++) step(1'b1);
        bus.ce = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_reset", dut_out(), RST_VAL);
        last = RST_VAL;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        fc_base = 0;
        k_force = 0;

        for (int i = 0; i < int'(HT * 3); i++) step(1'($urandom_range(0, 3) != 0));

        // Preload the frame counter just below its wrap point.
        bus.ce = 1'b0;
        force dut.frame_cnt = 16'hFFFF;
        fc_base = 65535;
        k_force = k;
        last[15:0] = 16'hFFFF;
        #1 release dut.frame_cnt;
        @(negedge clk);
        for (int i = 0; i < int'(FT + 30); i++) step(1'b1);

        step(1'b0);
        step(1'b0);
        check("sb_drained", 41'(sb_q.size()), 41'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
